// File: rtl/pamux_byte_bridge.sv
// Byte-wide pamux server port bridged onto 16-bit PSRAM controller word transactions.
// Writes are posted with byte enables; reads are served from a one-word cache when possible.
module pamux_byte_bridge #(
  parameter bit          CACHE_EN   = 1'b1,
  parameter int unsigned RD_TIMEOUT = 255
) (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic [21:0] i_ADDR22,
  input  logic        i_WRITE,
  input  logic        i_READ,
  input  logic [7:0]  i_WDATA8,
  output logic [7:0]  o_RDATA8,
  output logic        o_BUSY,
  output logic        o_MC_REQ,
  input  logic        i_MC_ACK,
  output logic        o_MC_WE,
  output logic [20:0] o_MC_ADDR21,
  output logic [15:0] o_MC_WDATA16,
  output logic [1:0]  o_MC_BE2,
  input  logic        i_MC_RVALID,
  input  logic [15:0] i_MC_RDATA16,
  output logic        o_TIMEOUT
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_WAIT_RD = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [7:0] RD_LIMIT = 8'(RD_TIMEOUT);

  logic [1:0]  state_q,     state_d;
  logic        busy_q,      busy_d;
  logic        req_q,       req_d;
  logic        we_q,        we_d;
  logic [21:0] addr_q,      addr_d;
  logic [7:0]  wdata_q,     wdata_d;
  logic [7:0]  rdata_q,     rdata_d;
  logic        timeout_q,   timeout_d;
  logic [15:0] cache_q,     cache_d;
  logic [20:0] tag_q,       tag_d;
  logic        cache_vld_q, cache_vld_d;
  logic [7:0]  cnt_q,       cnt_d;

  logic cache_hit;
  assign cache_hit = CACHE_EN && cache_vld_q && (tag_q == i_ADDR22[21:1]);

  always_comb begin
    // NOTE: every _d starts as its _q so no path through the case leaves a signal unassigned (no latches).
    state_d     = state_q;
    busy_d      = busy_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    timeout_d   = timeout_q;
    cache_d     = cache_q;
    tag_d       = tag_q;
    cache_vld_d = cache_vld_q;
    cnt_d       = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (i_WRITE) begin
          addr_d  = i_ADDR22;
          wdata_d = i_WDATA8;
          busy_d  = 1'b1;
          req_d   = 1'b1;
          we_d    = 1'b1;
          state_d = S_REQ;
        end else if (i_READ) begin
          busy_d = 1'b1;
          if (cache_hit) begin
            rdata_d = i_ADDR22[0] ? cache_q[15:8] : cache_q[7:0];
            state_d = S_DONE;
          end else begin
            addr_d  = i_ADDR22;
            req_d   = 1'b1;
            we_d    = 1'b0;
            state_d = S_REQ;
          end
        end
      end

      S_REQ: begin
        if (i_MC_ACK) begin
          req_d = 1'b0;
          if (we_q) begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
            // Write-through keeps the cached word coherent with PSRAM.
            if (cache_vld_q && (tag_q == addr_q[21:1])) begin
              if (addr_q[0]) cache_d[15:8] = wdata_q;
              else           cache_d[7:0]  = wdata_q;
            end
          end else begin
            cnt_d   = 8'd0;
            state_d = S_WAIT_RD;
          end
        end
      end

      S_WAIT_RD: begin
        if (i_MC_RVALID) begin
          cache_d     = i_MC_RDATA16;
          tag_d       = addr_q[21:1];
          cache_vld_d = CACHE_EN;
          rdata_d     = addr_q[0] ? i_MC_RDATA16[15:8] : i_MC_RDATA16[7:0];
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end else if (cnt_q + 8'd1 == RD_LIMIT) begin
          rdata_d     = 8'hFF;
          timeout_d   = 1'b1;
          cache_vld_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_CLK) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (i_RST) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= 8'hCC;
      timeout_q   <= 1'b0;
      cache_q     <= '0;
      tag_q       <= '0;
      cache_vld_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      timeout_q   <= timeout_d;
      cache_q     <= cache_d;
      tag_q       <= tag_d;
      cache_vld_q <= cache_vld_d;
      cnt_q       <= cnt_d;
    end
  end

  assign o_RDATA8     = rdata_q;
  assign o_BUSY       = busy_q;
  assign o_MC_REQ     = req_q;
  assign o_MC_WE      = we_q;
  assign o_MC_ADDR21  = addr_q[21:1];
  assign o_MC_WDATA16 = {wdata_q, wdata_q};
  assign o_MC_BE2     = addr_q[0] ? 2'b10 : 2'b01;
  assign o_TIMEOUT    = timeout_q;

endmodule
